printer_fifo: RTL and testbench

PRINTER_FIFO -- requirements
Module: printer_fifo

---
 rtl/printer_fifo.sv | 110 +++++++++++
 tb/tb_printer_fifo.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/printer_fifo.sv
// Byte FIFO between Z80 writes to the printer port and ESP reads over SPI.
// Status byte, occupancy and an empty-to-non-empty request pulse are derived from registered state.
module printer_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  RST_N,
  input  logic                  wr_stb,
  input  logic [7:0]            wr_data,
  input  logic                  pop,
  output logic [7:0]            pop_data,
  output logic                  pop_valid,
  input  logic                  clr,
  output logic [7:0]            status,
  output logic                  not_empty,
  output logic                  esp_req,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_ZERO = (DEPTH_LOG2+1)'(0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(0);

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic [7:0]            r_pop_data;
  logic                  r_pop_valid;
  logic                  r_esp_req;
  logic                  r_overflow;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_do_wr;
  logic                  w_do_rd;
  logic                  w_ovf_set;
  logic [DEPTH_LOG2:0]   w_level_nxt;

  // Accept/drop decisions and next occupancy; a pop at full frees the slot the write needs.
  always_comb begin
    w_empty     = (r_level == LVL_ZERO);
    w_full      = (r_level == LVL_FULL);
    w_do_wr     = wr_stb & (~w_full | pop);
    w_do_rd     = pop & ~w_empty;
    w_ovf_set   = wr_stb & w_full & ~pop;
    w_level_nxt = r_level;
    case ({w_do_wr, w_do_rd})
      2'b10:   w_level_nxt = r_level + LVL_ONE;
      2'b01:   w_level_nxt = r_level - LVL_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  // Pointer, occupancy and pop/request state; clr outranks both strobes.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_rptr      <= PTR_ZERO;
      r_wptr      <= PTR_ZERO;
      r_level     <= LVL_ZERO;
      r_pop_data  <= 8'h00;
      r_pop_valid <= 1'b0;
      r_esp_req   <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (clr) begin
      r_rptr      <= PTR_ZERO;
      r_wptr      <= PTR_ZERO;
      r_level     <= LVL_ZERO;
      r_pop_valid <= 1'b0;
      r_esp_req   <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_do_wr) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_do_rd) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      if (pop) begin
        r_pop_data <= w_do_rd ? r_mem[r_rptr] : 8'h00;
      end
      r_pop_valid <= pop;
      r_level     <= w_level_nxt;
      r_esp_req   <= w_empty & (w_level_nxt != LVL_ZERO);
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Buffer storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_do_wr && !clr) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  assign pop_data  = r_pop_data;
  assign pop_valid = r_pop_valid;
  assign esp_req   = r_esp_req;
  assign overflow  = r_overflow;
  assign level     = r_level;
  assign not_empty = ~w_empty;
  assign status    = {w_full, 1'b0, 1'b1, 1'b1, 4'b0000};

endmodule

// File: tb/tb_printer_fifo.sv
// Directed, table-driven check of printer_fifo plus hand-written async-reset sequence.
module tb_printer_fifo;

  logic       clk;
  logic       RST_N;
  logic       wr_stb;
  logic [7:0] wr_data;
  logic       pop;
  logic [7:0] pop_data;
  logic       pop_valid;
  logic       clr;
  logic [7:0] status;
  logic       not_empty;
  logic       esp_req;
  logic [4:0] level;
  logic       overflow;

  printer_fifo #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .RST_N(RST_N), .wr_stb(wr_stb), .wr_data(wr_data), .pop(pop),
    .pop_data(pop_data), .pop_valid(pop_valid), .clr(clr), .status(status),
    .not_empty(not_empty), .esp_req(esp_req), .level(level), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       pp;
    logic       cl;
    logic       e_pv;
    logic [7:0] e_pd;
    int         e_lvl;
    logic       e_ov;
    logic       e_esp;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  function automatic void add(logic wr, logic [7:0] wd, logic pp, logic cl,
                              logic pv, logic [7:0] pd, int lvl, logic ov, logic esp);
    vec_t v;
    v.wr = wr; v.wd = wd; v.pp = pp; v.cl = cl;
    v.e_pv = pv; v.e_pd = pd; v.e_lvl = lvl; v.e_ov = ov; v.e_esp = esp;
    vq.push_back(v);
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d actual %0h required %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_state(int idx, logic pv, logic [7:0] pd, int lvl, logic ov, logic esp, logic cmp_pd);
    chk("pop_valid", idx, {31'd0, pop_valid}, {31'd0, pv});
    if (cmp_pd) chk("pop_data", idx, {24'd0, pop_data}, {24'd0, pd});
    chk("level", idx, {27'd0, level}, lvl);
    chk("overflow", idx, {31'd0, overflow}, {31'd0, ov});
    chk("esp_req", idx, {31'd0, esp_req}, {31'd0, esp});
    chk("not_empty", idx, {31'd0, not_empty}, {31'd0, (lvl != 0)});
    chk("status", idx, {24'd0, status}, (lvl == 16) ? 32'hB0 : 32'h30);
  endtask

  task automatic drive(logic wr, logic [7:0] wd, logic pp, logic cl);
    wr_stb = wr; wr_data = wd; pop = pp; clr = cl;
  endtask

  initial begin
    RST_N = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Basic ordering, single esp_req pulse, empty pop, write+pop at empty/mid, clr priority
    add(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b1);
    add(1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 8'h00, 2, 1'b0, 1'b0);
    add(1'b1, 8'h43, 1'b0, 1'b0, 1'b0, 8'h00, 3, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h41, 2, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h42, 1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h43, 0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h43, 0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0);
    add(1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b1);
    add(1'b1, 8'h78, 1'b1, 1'b0, 1'b1, 8'h77, 1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h78, 0, 1'b0, 1'b0);
    add(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b1);
    add(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 2, 1'b0, 1'b0);
    add(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00, 3, 1'b0, 1'b0);
    add(1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0);
    // Fill to 16, overflow on 17th, drain 00..0F, then clr clears overflow
    for (int i = 0; i < 16; i++)
      add(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 8'h00, i + 1, 1'b0, (i == 0));
    add(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 16, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++)
      add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'(i), 15 - i, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    // Write+pop at full: oldest out, 55 in, no overflow, 55 drains last
    for (int i = 0; i < 16; i++)
      add(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0, 8'h00, i + 1, 1'b0, (i == 0));
    add(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'hC0, 16, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++)
      add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'(8'hC1 + i), 15 - i, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h55, 0, 1'b0, 1'b0);
    // Pointer wrap-around
    for (int i = 0; i < 12; i++)
      add(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 8'h00, i + 1, 1'b0, (i == 0));
    for (int i = 0; i < 12; i++)
      add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'(8'h10 + i), 11 - i, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      add(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0, 8'h00, i + 1, 1'b0, (i == 0));
    for (int i = 0; i < 10; i++)
      add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'(8'hA0 + i), 9 - i, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    RST_N = 1'b1;
    chk_state(-1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1);

    foreach (vq[k]) begin
      drive(vq[k].wr, vq[k].wd, vq[k].pp, vq[k].cl);
      @(posedge clk);
      #1;
      chk_state(k, vq[k].e_pv, vq[k].e_pd, vq[k].e_lvl, vq[k].e_ov, vq[k].e_esp, vq[k].e_pv);
    end

    // Async reset mid-operation at level 5 with a pop_valid pulse in flight
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk_state(1000, 1'b1, 8'h60, 5, 1'b0, 1'b0, 1'b1);
    #2;
    RST_N = 1'b0;
    #1;
    chk_state(1001, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    RST_N = 1'b1;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk_state(1002, 1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
